// File: rtl/i2c_fifo_block.sv
// ---------------------------------------------------------------------------
// i2c_fifo_block
//
// Purpose: two first-word-fall-through synchronous FIFOs that sit in front of
// the I2C master. The transmit FIFO is filled by the register interface and
// drained by the master. The receive FIFO is filled by the master datapath
// and drained by the register interface. Each FIFO has an occupancy count and
// sticky overflow/underflow flags.
//
// Optional feature macro: I2C_FIFO_THRESHOLD_EN
//   When defined, the almost-full / almost-empty ports are added for both
//   FIFOs. They are computed from the registered count and the
//   ALMOST_FULL_LEVEL / ALMOST_EMPTY_LEVEL parameters.
//
// Ports (i2c_fifo_block):
//   i2c_core_clock_i      core clock, rising edge
//   reset_bit_i           synchronous active-high reset, highest priority
//   clear_trans_fifo_i    flush the transmit FIFO and its sticky flags
//   clear_rev_fifo_i      flush the receive FIFO and its sticky flags
//   clear_status_i        clear all four sticky flags (a same-cycle error wins)
//   cpu_wr_en_i/_data_i   push into the transmit FIFO
//   master_rd_en_i        pop from the transmit FIFO
//   trans_data_o          transmit head byte, 0 while empty
//   trans_fifo_*_o        transmit empty / full / count
//   master_wr_en_i/_data_i push into the receive FIFO
//   cpu_rd_en_i           pop from the receive FIFO
//   rev_data_o            receive head byte, 0 while empty
//   rev_fifo_*_o          receive empty / full / count
//   *_overflow_o/_underflow_o  sticky error flags
//   *_almost_full_o/_almost_empty_o  threshold flags (optional)
// ---------------------------------------------------------------------------

// One FWFT FIFO. Both FIFOs of the block use this structure.
module i2c_fifo_core #(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 16,
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  i_flush,
    input  logic                  i_clear_status,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
`ifdef I2C_FIFO_THRESHOLD_EN
    ,
    output logic                  o_almost_full,
    output logic                  o_almost_empty
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    // Elaboration-time sanity checks on the configuration.
    if (DEPTH < 2 || ADDR_WIDTH != $clog2(DEPTH) || (1 << ADDR_WIDTH) != DEPTH) begin : g_bad_depth
        $error("i2c_fifo_core: DEPTH must be a power of two >= 2 and ADDR_WIDTH = log2(DEPTH)");
    end
    if (ALMOST_FULL_LEVEL > DEPTH || ALMOST_EMPTY_LEVEL > DEPTH) begin : g_bad_level
        $error("i2c_fifo_core: threshold levels must not exceed DEPTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    // Status comes only from the registered count, so enables never reach
    // empty/full combinationally.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);
    assign w_push_ok = i_wr_en && !w_full;
    assign w_pop_ok  = i_rd_en && !w_empty;

    // Storage is never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!srst && !i_flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A new error event outranks a same-cycle status clear.
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_clear_status) begin
                r_overflow <= 1'b0;
            end
            if (i_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (i_clear_status) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // First-word-fall-through head; reads as zero whenever nothing is valid.
    assign o_rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

`ifdef I2C_FIFO_THRESHOLD_EN
    assign o_almost_full  = (r_count >= (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL));
    assign o_almost_empty = (r_count <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL));
`endif

endmodule

module i2c_fifo_block #(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 16,
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                  i2c_core_clock_i,
    input  logic                  reset_bit_i,
    input  logic                  clear_trans_fifo_i,
    input  logic                  clear_rev_fifo_i,
    input  logic                  clear_status_i,
    input  logic                  cpu_wr_en_i,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
    input  logic                  master_rd_en_i,
    output logic [DATA_WIDTH-1:0] trans_data_o,
    output logic                  trans_fifo_empty_o,
    output logic                  trans_fifo_full_o,
    output logic [ADDR_WIDTH:0]   trans_count_o,
    input  logic                  master_wr_en_i,
    input  logic [DATA_WIDTH-1:0] master_wr_data_i,
    input  logic                  cpu_rd_en_i,
    output logic [DATA_WIDTH-1:0] rev_data_o,
    output logic                  rev_fifo_empty_o,
    output logic                  rev_fifo_full_o,
    output logic [ADDR_WIDTH:0]   rev_count_o,
    output logic                  trans_overflow_o,
    output logic                  trans_underflow_o,
    output logic                  rev_overflow_o,
    output logic                  rev_underflow_o
`ifdef I2C_FIFO_THRESHOLD_EN
    ,
    output logic                  trans_almost_full_o,
    output logic                  trans_almost_empty_o,
    output logic                  rev_almost_full_o,
    output logic                  rev_almost_empty_o
`endif
);

    i2c_fifo_core #(
        .DATA_WIDTH         (DATA_WIDTH),
        .DEPTH              (DEPTH),
        .ADDR_WIDTH         (ADDR_WIDTH),
        .ALMOST_FULL_LEVEL  (ALMOST_FULL_LEVEL),
        .ALMOST_EMPTY_LEVEL (ALMOST_EMPTY_LEVEL)
    ) u_trans_fifo (
        .clk            (i2c_core_clock_i),
        .srst           (reset_bit_i),
        .i_flush        (clear_trans_fifo_i),
        .i_clear_status (clear_status_i),
        .i_wr_en        (cpu_wr_en_i),
        .i_wr_data      (cpu_wr_data_i),
        .i_rd_en        (master_rd_en_i),
        .o_rd_data      (trans_data_o),
        .o_empty        (trans_fifo_empty_o),
        .o_full         (trans_fifo_full_o),
        .o_count        (trans_count_o),
        .o_overflow     (trans_overflow_o),
        .o_underflow    (trans_underflow_o)
`ifdef I2C_FIFO_THRESHOLD_EN
        ,
        .o_almost_full  (trans_almost_full_o),
        .o_almost_empty (trans_almost_empty_o)
`endif
    );

    i2c_fifo_core #(
        .DATA_WIDTH         (DATA_WIDTH),
        .DEPTH              (DEPTH),
        .ADDR_WIDTH         (ADDR_WIDTH),
        .ALMOST_FULL_LEVEL  (ALMOST_FULL_LEVEL),
        .ALMOST_EMPTY_LEVEL (ALMOST_EMPTY_LEVEL)
    ) u_rev_fifo (
        .clk            (i2c_core_clock_i),
        .srst           (reset_bit_i),
        .i_flush        (clear_rev_fifo_i),
        .i_clear_status (clear_status_i),
        .i_wr_en        (master_wr_en_i),
        .i_wr_data      (master_wr_data_i),
        .i_rd_en        (cpu_rd_en_i),
        .o_rd_data      (rev_data_o),
        .o_empty        (rev_fifo_empty_o),
        .o_full         (rev_fifo_full_o),
        .o_count        (rev_count_o),
        .o_overflow     (rev_overflow_o),
        .o_underflow    (rev_underflow_o)
`ifdef I2C_FIFO_THRESHOLD_EN
        ,
        .o_almost_full  (rev_almost_full_o),
        .o_almost_empty (rev_almost_empty_o)
`endif
    );

endmodule

// File: tb/tb_i2c_fifo_block.sv
module tb_i2c_fifo_block;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF_LVL = 12;
    localparam int AE_LVL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_t;
    logic          clr_r;
    logic          clr_s;
    logic          cpu_wr_en;
    logic [DW-1:0] cpu_wr_data;
    logic          master_rd_en;
    logic          master_wr_en;
    logic [DW-1:0] master_wr_data;
    logic          cpu_rd_en;

    logic [DW-1:0] trans_data;
    logic          trans_empty, trans_full;
    logic [AW:0]   trans_count;
    logic [DW-1:0] rev_data;
    logic          rev_empty, rev_full;
    logic [AW:0]   rev_count;
    logic          t_ovf_o, t_unf_o, r_ovf_o, r_unf_o;
`ifdef I2C_FIFO_THRESHOLD_EN
    logic          t_af_o, t_ae_o, r_af_o, r_ae_o;
`endif

    always #5 clk = ~clk;

    i2c_fifo_block #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .ALMOST_FULL_LEVEL(AF_LVL), .ALMOST_EMPTY_LEVEL(AE_LVL)
    ) dut (
        .i2c_core_clock_i   (clk),
        .reset_bit_i        (rst),
        .clear_trans_fifo_i (clr_t),
        .clear_rev_fifo_i   (clr_r),
        .clear_status_i     (clr_s),
        .cpu_wr_en_i        (cpu_wr_en),
        .cpu_wr_data_i      (cpu_wr_data),
        .master_rd_en_i     (master_rd_en),
        .trans_data_o       (trans_data),
        .trans_fifo_empty_o (trans_empty),
        .trans_fifo_full_o  (trans_full),
        .trans_count_o      (trans_count),
        .master_wr_en_i     (master_wr_en),
        .master_wr_data_i   (master_wr_data),
        .cpu_rd_en_i        (cpu_rd_en),
        .rev_data_o         (rev_data),
        .rev_fifo_empty_o   (rev_empty),
        .rev_fifo_full_o    (rev_full),
        .rev_count_o        (rev_count),
        .trans_overflow_o   (t_ovf_o),
        .trans_underflow_o  (t_unf_o),
        .rev_overflow_o     (r_ovf_o),
        .rev_underflow_o    (r_unf_o)
`ifdef I2C_FIFO_THRESHOLD_EN
        ,
        .trans_almost_full_o  (t_af_o),
        .trans_almost_empty_o (t_ae_o),
        .rev_almost_full_o    (r_af_o),
        .rev_almost_empty_o   (r_ae_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference: each FIFO is a queue plus two sticky bits.
    logic [DW-1:0] tq[$];
    logic [DW-1:0] rq[$];
    bit m_t_ovf, m_t_unf, m_r_ovf, m_r_unf;

    task automatic model_update();
        bit t_was_full, t_was_empty, r_was_full, r_was_empty;
        if (rst) begin
            tq.delete(); rq.delete();
            m_t_ovf = 0; m_t_unf = 0; m_r_ovf = 0; m_r_unf = 0;
        end else begin
            if (clr_t) begin
                tq.delete(); m_t_ovf = 0; m_t_unf = 0;
            end else begin
                t_was_full  = (tq.size() == DEPTH);
                t_was_empty = (tq.size() == 0);
                if (master_rd_en && !t_was_empty) void'(tq.pop_front());
                if (cpu_wr_en && !t_was_full) tq.push_back(cpu_wr_data);
                m_t_ovf = (m_t_ovf && !clr_s) || (cpu_wr_en && t_was_full);
                m_t_unf = (m_t_unf && !clr_s) || (master_rd_en && t_was_empty);
            end
            if (clr_r) begin
                rq.delete(); m_r_ovf = 0; m_r_unf = 0;
            end else begin
                r_was_full  = (rq.size() == DEPTH);
                r_was_empty = (rq.size() == 0);
                if (cpu_rd_en && !r_was_empty) void'(rq.pop_front());
                if (master_wr_en && !r_was_full) rq.push_back(master_wr_data);
                m_r_ovf = (m_r_ovf && !clr_s) || (master_wr_en && r_was_full);
                m_r_unf = (m_r_unf && !clr_s) || (cpu_rd_en && r_was_empty);
            end
        end
    endtask

    task automatic idle();
        rst = 0; clr_t = 0; clr_r = 0; clr_s = 0;
        cpu_wr_en = 0; cpu_wr_data = '0; master_rd_en = 0;
        master_wr_en = 0; master_wr_data = '0; cpu_rd_en = 0;
    endtask

    // One clock: model follows the DUT at the edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cpu_wr_en = 1; cpu_wr_data = 8'h33; master_wr_en = 1; master_wr_data = 8'h44;
        tick();
        // Reset with every other request asserted: reset must win.
        rst = 1; cpu_wr_en = 1; master_rd_en = 1; master_wr_en = 1; cpu_rd_en = 1;
        clr_t = 1;
        tick();
        idle();
        n_tests++; if (trans_count !== 5'd0 || trans_empty !== 1'b1 || trans_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_trans: count=%0d empty=%b full=%b, want 0 1 0", trans_count, trans_empty, trans_full);
        end
        n_tests++; if (rev_count !== 5'd0 || rev_empty !== 1'b1 || rev_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_rev: count=%0d empty=%b full=%b, want 0 1 0", rev_count, rev_empty, rev_full);
        end
        n_tests++; if (trans_data !== 8'h00 || rev_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: trans=%h rev=%h, want 00 00", trans_data, rev_data);
        end
        n_tests++; if ({t_ovf_o, t_unf_o, r_ovf_o, r_unf_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b, want 0000", {t_ovf_o, t_unf_o, r_ovf_o, r_unf_o});
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        cpu_wr_en = 1; cpu_wr_data = 8'hA5; tick(); idle();
        n_tests++; if (trans_data !== 8'hA5 || trans_empty !== 1'b0 || trans_count !== 5'd1) begin
            n_fail++; $display("FAIL basic_push: data=%h empty=%b count=%0d, want a5 0 1", trans_data, trans_empty, trans_count);
        end
        master_rd_en = 1; tick(); idle();
        n_tests++; if (trans_empty !== 1'b1 || trans_data !== 8'h00 || trans_count !== 5'd0) begin
            n_fail++; $display("FAIL basic_pop: empty=%b data=%h count=%0d, want 1 00 0", trans_empty, trans_data, trans_count);
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_fill_overflow();
        int bad;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cpu_wr_en = 1; cpu_wr_data = 8'(i); tick();
        end
        idle();
        n_tests++; if (trans_full !== 1'b1 || trans_count !== 5'd16) begin
            n_fail++; $display("FAIL fill_full: full=%b count=%0d, want 1 16", trans_full, trans_count);
        end
        cpu_wr_en = 1; cpu_wr_data = 8'hFF; tick(); idle();
        n_tests++; if (t_ovf_o !== 1'b1 || trans_count !== 5'd16 || trans_data !== 8'h00) begin
            n_fail++; $display("FAIL fill_overflow: ovf=%b count=%0d head=%h, want 1 16 00", t_ovf_o, trans_count, trans_data);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (trans_data !== 8'(i)) begin
                bad++; $display("FAIL fill_order[%0d]: got %h, want %h", i, trans_data, 8'(i));
            end
            master_rd_en = 1; tick();
        end
        idle();
        n_tests++; if (bad != 0) n_fail++;
        n_tests++; if (trans_empty !== 1'b1 || t_ovf_o !== 1'b1) begin
            n_fail++; $display("FAIL fill_drained: empty=%b ovf=%b, want 1 1", trans_empty, t_ovf_o);
        end
        clr_s = 1; tick(); idle();
        n_tests++; if (t_ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL clear_status: ovf=%b, want 0", t_ovf_o);
        end
        $display("[TB] test_fill_overflow done");
    endtask

    task automatic test_rev_wrap();
        int bad;
        int wr_idx;
        do_reset();
        wr_idx = 0;
        for (int i = 0; i < 3; i++) begin
            master_wr_en = 1; master_wr_data = 8'(wr_idx * 7 + 1); wr_idx++; tick();
        end
        idle();
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            if (rev_data !== 8'(j * 7 + 1)) begin
                bad++; $display("FAIL wrap_data[%0d]: got %h, want %h", j, rev_data, 8'(j * 7 + 1));
            end
            master_wr_en = 1; master_wr_data = 8'(wr_idx * 7 + 1); wr_idx++;
            cpu_rd_en = 1; tick(); idle();
            if (rev_count !== 5'd3) begin
                bad++; $display("FAIL wrap_count[%0d]: got %0d, want 3", j, rev_count);
            end
        end
        n_tests++; if (bad != 0) n_fail++;
        for (int i = 0; i < 3; i++) begin cpu_rd_en = 1; tick(); end
        idle();
        n_tests++; if (rev_empty !== 1'b1 || r_unf_o !== 1'b0) begin
            n_fail++; $display("FAIL wrap_drain: empty=%b unf=%b, want 1 0", rev_empty, r_unf_o);
        end
        $display("[TB] test_rev_wrap done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            master_wr_en = 1; master_wr_data = 8'(8'h80 + i); tick();
        end
        master_wr_en = 1; master_wr_data = 8'hEE; cpu_rd_en = 1; tick(); idle();
        n_tests++; if (rev_count !== 5'd15 || r_ovf_o !== 1'b1 || rev_data !== 8'h81) begin
            n_fail++; $display("FAIL simul_full: count=%0d ovf=%b head=%h, want 15 1 81", rev_count, r_ovf_o, rev_data);
        end
        for (int i = 0; i < 15; i++) begin cpu_rd_en = 1; tick(); end
        clr_s = 1; cpu_rd_en = 0; tick(); idle();
        master_wr_en = 1; master_wr_data = 8'h5C; cpu_rd_en = 1; tick(); idle();
        n_tests++; if (rev_count !== 5'd1 || r_unf_o !== 1'b1 || rev_data !== 8'h5C) begin
            n_fail++; $display("FAIL simul_empty: count=%0d unf=%b head=%h, want 1 1 5c", rev_count, r_unf_o, rev_data);
        end
        for (int i = 0; i < 4; i++) begin master_wr_en = 1; master_wr_data = 8'(i); tick(); end
        master_wr_en = 1; master_wr_data = 8'h99; cpu_rd_en = 1; tick(); idle();
        n_tests++; if (rev_count !== 5'd5 || rev_data !== 8'h00) begin
            n_fail++; $display("FAIL simul_mid: count=%0d head=%h, want 5 00", rev_count, rev_data);
        end
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_flush();
        do_reset();
        master_wr_en = 1; master_wr_data = 8'h11; tick();
        master_wr_data = 8'h22; tick(); idle();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cpu_wr_en = 1; cpu_wr_data = 8'(8'h40 + i); tick();
        end
        idle();
        for (int i = 0; i < 9; i++) begin master_rd_en = 1; tick(); end
        idle();
        n_tests++; if (trans_count !== 5'd7 || t_ovf_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre: count=%0d ovf=%b, want 7 1", trans_count, t_ovf_o);
        end
        clr_t = 1; cpu_wr_en = 1; cpu_wr_data = 8'h77; master_rd_en = 1; tick(); idle();
        n_tests++; if (trans_count !== 5'd0 || trans_empty !== 1'b1 || t_ovf_o !== 1'b0 || trans_data !== 8'h00) begin
            n_fail++; $display("FAIL flush_trans: count=%0d empty=%b ovf=%b data=%h, want 0 1 0 00",
                               trans_count, trans_empty, t_ovf_o, trans_data);
        end
        n_tests++; if (rev_count !== 5'd2 || rev_data !== 8'h11) begin
            n_fail++; $display("FAIL flush_rev_intact: count=%0d head=%h, want 2 11", rev_count, rev_data);
        end
        $display("[TB] test_flush done");
    endtask

`ifdef I2C_FIFO_THRESHOLD_EN
    task automatic test_threshold();
        do_reset();
        n_tests++; if (t_ae_o !== 1'b1 || t_af_o !== 1'b0 || r_ae_o !== 1'b1 || r_af_o !== 1'b0) begin
            n_fail++; $display("FAIL thr_reset: t_ae=%b t_af=%b r_ae=%b r_af=%b, want 1 0 1 0", t_ae_o, t_af_o, r_ae_o, r_af_o);
        end
        for (int i = 0; i < 11; i++) begin cpu_wr_en = 1; cpu_wr_data = 8'(i); tick(); end
        idle();
        n_tests++; if (t_af_o !== 1'b0) begin
            n_fail++; $display("FAIL thr_af11: got %b, want 0", t_af_o);
        end
        cpu_wr_en = 1; tick(); idle();
        n_tests++; if (t_af_o !== 1'b1) begin
            n_fail++; $display("FAIL thr_af12: got %b, want 1", t_af_o);
        end
        for (int i = 0; i < 7; i++) begin master_rd_en = 1; tick(); end
        idle();
        n_tests++; if (t_ae_o !== 1'b0 || trans_count !== 5'd5) begin
            n_fail++; $display("FAIL thr_ae5: ae=%b count=%0d, want 0 5", t_ae_o, trans_count);
        end
        master_rd_en = 1; tick(); idle();
        n_tests++; if (t_ae_o !== 1'b1) begin
            n_fail++; $display("FAIL thr_ae4: got %b, want 1", t_ae_o);
        end
        for (int i = 0; i < 3; i++) begin cpu_wr_en = 1; master_wr_en = 1; tick(); end
        rst = 1; cpu_wr_en = 1; master_wr_en = 1; tick(); idle();
        n_tests++; if (trans_count !== 5'd0 || rev_count !== 5'd0 || t_ae_o !== 1'b1 || r_ae_o !== 1'b1) begin
            n_fail++; $display("FAIL thr_midreset: tc=%0d rc=%0d t_ae=%b r_ae=%b, want 0 0 1 1",
                               trans_count, rev_count, t_ae_o, r_ae_o);
        end
        $display("[TB] test_threshold done");
    endtask
`endif

    task automatic test_random();
        int p_push, p_pop, ts, rs;
        logic [16:0] act_t, exp_t, act_r, exp_r;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) begin
                p_push = $urandom_range(10, 90);
                p_pop  = $urandom_range(10, 90);
            end
            rst            = ($urandom_range(0, 299) == 0);
            clr_t          = ($urandom_range(0, 79) == 0);
            clr_r          = ($urandom_range(0, 79) == 0);
            clr_s          = ($urandom_range(0, 39) == 0);
            cpu_wr_en      = ($urandom_range(0, 99) < p_push);
            cpu_wr_data    = 8'($urandom);
            master_rd_en   = ($urandom_range(0, 99) < p_pop);
            master_wr_en   = ($urandom_range(0, 99) < p_push);
            master_wr_data = 8'($urandom);
            cpu_rd_en      = ($urandom_range(0, 99) < p_pop);
            tick();
            ts = tq.size();
            rs = rq.size();
            act_t = {trans_data, trans_empty, trans_full, trans_count, t_ovf_o, t_unf_o};
            exp_t = {(ts != 0) ? tq[0] : 8'h00, ts == 0, ts == DEPTH, 5'(ts), m_t_ovf, m_t_unf};
            act_r = {rev_data, rev_empty, rev_full, rev_count, r_ovf_o, r_unf_o};
            exp_r = {(rs != 0) ? rq[0] : 8'h00, rs == 0, rs == DEPTH, 5'(rs), m_r_ovf, m_r_unf};
            n_tests++; if (act_t !== exp_t) begin
                n_fail++; $display("FAIL rand_trans cyc %0d: {data,empty,full,count,ovf,unf} got %h, want %h", cyc, act_t, exp_t);
            end
            n_tests++; if (act_r !== exp_r) begin
                n_fail++; $display("FAIL rand_rev cyc %0d: {data,empty,full,count,ovf,unf} got %h, want %h", cyc, act_r, exp_r);
            end
`ifdef I2C_FIFO_THRESHOLD_EN
            n_tests++; if ({t_af_o, t_ae_o, r_af_o, r_ae_o} !== {ts >= AF_LVL, ts <= AE_LVL, rs >= AF_LVL, rs <= AE_LVL}) begin
                n_fail++; $display("FAIL rand_thr cyc %0d: got %b, want %b", cyc, {t_af_o, t_ae_o, r_af_o, r_ae_o},
                                   {ts >= AF_LVL, ts <= AE_LVL, rs >= AF_LVL, rs <= AE_LVL});
            end
`endif
        end
        idle();
        $display("[TB] test_random done");
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_fill_overflow();
        test_rev_wrap();
        test_simultaneous();
        test_flush();
`ifdef I2C_FIFO_THRESHOLD_EN
        test_threshold();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
